// File: rtl/load_scoreboard.sv
// load_scoreboard: records the destination of the single outstanding load and stalls DE on RAW, WAW or memory-port conflicts.
// Optional load timeout is enabled by defining LOAD_SCOREBOARD_TIMEOUT_EN.
module load_scoreboard #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_DE,
    input  logic        instr_DE_valid,
    input  logic        load_ack,
    output logic        stall_DE,
    output logic        load_busy,
    output logic [4:0]  pending_rd,
    output logic        timeout_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_OP     = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // CNT_W is derived from MAX_WAIT; overriding it independently is an elaboration error.
    if (MAX_WAIT < 1 || CNT_W != $clog2(MAX_WAIT + 1)) begin : g_bad_params
        $error("load_scoreboard: invalid MAX_WAIT/CNT_W combination");
    end

    logic [0:0] state;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_mem;
    logic       raw_hazard;
    logic       waw_hazard;
    logic       issue;
    logic       timeout_hit;
    logic       unused_instr_bits;

    assign opcode = instr_DE[6:0];
    assign rd     = instr_DE[11:7];
    assign rs1    = instr_DE[19:15];
    assign rs2    = instr_DE[24:20];
    assign unused_instr_bits = ^{instr_DE[31:25], instr_DE[14:12]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_mem    = 1'b0;
        case (opcode)
            OP_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                is_mem   = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_mem    = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // pending_rd is zero whenever idle or for a load to x0, so the nonzero test also masks x0.
    assign raw_hazard = (pending_rd != 5'd0) &&
                        ((uses_rs1 && (rs1 == pending_rd)) || (uses_rs2 && (rs2 == pending_rd)));
    assign waw_hazard = (pending_rd != 5'd0) && writes_rd && (rd == pending_rd);
    assign stall_DE   = (state == WAIT) && instr_DE_valid && (raw_hazard || waw_hazard || is_mem);
    assign issue      = instr_DE_valid && !stall_DE;

`ifdef LOAD_SCOREBOARD_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // An ack in the same cycle as the limit takes priority, so no error is raised then.
    assign timeout_hit = (state == WAIT) && !load_ack && (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            load_busy  <= 1'b0;
            pending_rd <= 5'd0;
        end else if (state == IDLE) begin
            if (issue && (opcode == OP_LOAD)) begin
                state      <= WAIT;
                load_busy  <= 1'b1;
                pending_rd <= rd;
            end
        end else begin
            if (load_ack || timeout_hit) begin
                state      <= IDLE;
                load_busy  <= 1'b0;
                pending_rd <= 5'd0;
            end
        end
    end

endmodule
